// File: rtl/seven_seg_scanner_if.sv
// ---------------------------------------------------------------------------
// seven_seg_scanner_if
// Bundles the display-value write path and the scanned-digit outputs of the
// seven-segment refresh controller.
//   Write side (master drives): en, lz_blank, load, load_data[31:0],
//     load_dp[7:0], wr_en, wr_addr[2:0], wr_data[3:0], wr_dp
//   Display side (slave drives): num[3:0], sel[2:0], dp, blank, scan_tick
// master : register/bus logic that writes display values
// slave  : the scanner itself
// ---------------------------------------------------------------------------
interface seven_seg_scanner_if;
  logic        en;
  logic        lz_blank;
  logic        load;
  logic [31:0] load_data;
  logic [7:0]  load_dp;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [3:0]  wr_data;
  logic        wr_dp;
  logic [3:0]  num;
  logic [2:0]  sel;
  logic        dp;
  logic        blank;
  logic        scan_tick;

  modport master (
    output en, lz_blank, load, load_data, load_dp,
           wr_en, wr_addr, wr_data, wr_dp,
    input  num, sel, dp, blank, scan_tick
  );

  modport slave (
    input  en, lz_blank, load, load_data, load_dp,
           wr_en, wr_addr, wr_data, wr_dp,
    output num, sel, dp, blank, scan_tick
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// ---------------------------------------------------------------------------
// seven_seg_scanner
// Time-multiplexed refresh controller for an eight-digit seven-segment
// display. Holds eight 4-bit digits plus decimal points and presents one
// digit at a time (value on num, index on sel) to the downstream segment and
// anode decoders, advancing every REFRESH_DIV clock cycles.
// Ports:
//   clk    : system clock, rising-edge
//   rst_n  : asynchronous active-low reset
//   bus    : seven_seg_scanner_if.slave
//            en        scan enable (low freezes scan and blanks display)
//            lz_blank  leading-zero suppression enable
//            load, load_data, load_dp        bulk write of all digits/DPs
//            wr_en, wr_addr, wr_data, wr_dp  single-digit write
//            num, sel, dp, blank             registered digit outputs
//            scan_tick                       one-cycle pulse after sel advances
// Parameter:
//   REFRESH_DIV : clock cycles each digit is shown (>= 2)
// ---------------------------------------------------------------------------
module seven_seg_scanner #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seven_seg_scanner_if.slave   bus
);

  localparam int unsigned  PW    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PLAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] PZERO = PW'(0);
  localparam logic [PW-1:0] PONE  = PW'(1);

  // Storage
  logic [3:0]    digit_r     [8];
  logic [7:0]    dpreg_r;
  logic [3:0]    digit_nxt_s [8];
  logic [7:0]    dpreg_nxt_s;

  // Prescaler and scan index
  logic [PW-1:0] pcnt_r;
  logic [PW-1:0] pcnt_nxt_s;
  logic [2:0]    sel_r;
  logic [2:0]    sel_nxt_s;
  logic          adv_s;

  // Leading-zero qualification per digit
  logic [7:0]    lz_s;

  // Registered outputs and their next values
  logic [3:0]    num_r;
  logic          dp_r;
  logic          blank_r;
  logic          scan_tick_r;
  logic [3:0]    num_nxt_s;
  logic          dp_nxt_s;
  logic          blank_nxt_s;

  // Storage next-state: bulk load first, single write then overrides its digit.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      digit_nxt_s[i] = digit_r[i];
    end
    dpreg_nxt_s = dpreg_r;
    if (bus.load) begin
      for (int i = 0; i < 8; i++) begin
        digit_nxt_s[i] = bus.load_data[4*i +: 4];
      end
      dpreg_nxt_s = bus.load_dp;
    end else begin
      dpreg_nxt_s = dpreg_r;
    end
    if (bus.wr_en) begin
      digit_nxt_s[bus.wr_addr] = bus.wr_data;
      dpreg_nxt_s[bus.wr_addr] = bus.wr_dp;
    end else begin
      dpreg_nxt_s = dpreg_nxt_s;
    end
  end

  // Prescaler next-state: count while enabled, advance sel on wrap, hold otherwise.
  always_comb begin
    pcnt_nxt_s = pcnt_r;
    sel_nxt_s  = sel_r;
    adv_s      = 1'b0;
    if (bus.en) begin
      if (pcnt_r == PLAST) begin
        pcnt_nxt_s = PZERO;
        sel_nxt_s  = sel_r + 3'd1;
        adv_s      = 1'b1;
      end else begin
        pcnt_nxt_s = pcnt_r + PONE;
      end
    end else begin
      pcnt_nxt_s = pcnt_r;
    end
  end

  // Leading-zero blank per digit: this digit and every higher one is zero and
  // its own DP is off. Digit 0 always stays lit so a value of zero shows "0".
  always_comb begin
    logic zero_above;
    lz_s = 8'h00;
    for (int i = 1; i < 8; i++) begin
      zero_above = 1'b1;
      for (int j = i; j < 8; j++) begin
        zero_above = zero_above & (digit_r[j] == 4'd0);
      end
      lz_s[i] = bus.lz_blank & zero_above & ~dpreg_r[i];
    end
  end

  // Output next-state, evaluated for the index sel will hold after this edge
  // so that sel and its digit data always change together.
  always_comb begin
    num_nxt_s   = digit_r[sel_nxt_s];
    blank_nxt_s = ~bus.en | lz_s[sel_nxt_s];
    dp_nxt_s    = dpreg_r[sel_nxt_s] & ~blank_nxt_s;
  end

  // Digit and DP storage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        digit_r[i] <= 4'd0;
      end
      dpreg_r <= 8'h00;
    end else begin
      for (int i = 0; i < 8; i++) begin
        digit_r[i] <= digit_nxt_s[i];
      end
      dpreg_r <= dpreg_nxt_s;
    end
  end

  // Prescaler, scan index and registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_r      <= PZERO;
      sel_r       <= 3'd0;
      num_r       <= 4'd0;
      dp_r        <= 1'b0;
      blank_r     <= 1'b0;
      scan_tick_r <= 1'b0;
    end else begin
      pcnt_r      <= pcnt_nxt_s;
      sel_r       <= sel_nxt_s;
      num_r       <= num_nxt_s;
      dp_r        <= dp_nxt_s;
      blank_r     <= blank_nxt_s;
      scan_tick_r <= adv_s;
    end
  end

  assign bus.num       = num_r;
  assign bus.sel       = sel_r;
  assign bus.dp        = dp_r;
  assign bus.blank     = blank_r;
  assign bus.scan_tick = scan_tick_r;

endmodule
